// File: rtl/usb_utmi_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | usb_utmi_pkg                                                             |
// | Shared types and defaults for the UTMI transmit arbiter.                 |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package usb_utmi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    GAP  = 2'd2
  } usb_tx_arb_state_t;

  localparam int USB_TX_ARB_IPG_DEFAULT = 4;

endpackage
`default_nettype wire

// File: rtl/usb_utmi_tx_arb_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | usb_utmi_tx_arb_if                                                       |
// | Requester-side and UTMI-side signals of the transmit arbiter.            |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface usb_utmi_tx_arb_if #(
  parameter int NREQ = 2
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*8-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   grant;
  logic              busy;
  logic              utmi_tx_valid;
  logic [7:0]        utmi_data_in;
  logic              utmi_tx_ready;
  logic              utmi_rx_active;

  // Environment side: requesters plus the PHY.
  modport master (
    output req_valid, req_data, utmi_tx_ready, utmi_rx_active,
    input  req_ready, grant, busy, utmi_tx_valid, utmi_data_in
  );

  // Arbiter side.
  modport slave (
    input  req_valid, req_data, utmi_tx_ready, utmi_rx_active,
    output req_ready, grant, busy, utmi_tx_valid, utmi_data_in
  );
endinterface
`default_nettype wire

// File: rtl/usb_rr_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | usb_rr_arb                                                               |
// | Round-robin picker with its rotating pointer register.                   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module usb_rr_arb #(
  parameter int NREQ = 2
) (
  input  wire logic            clk,
  input  wire logic            rst,
  input  wire logic [NREQ-1:0] req,
  input  wire logic            advance,
  output logic      [NREQ-1:0] winner
);
  localparam int              PW     = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [PW-1:0]   C_LAST = PW'(NREQ - 1);

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_idx;
  logic [PW-1:0] w_cand;
  logic          w_found;
  int            w_pos;

  // Search starts at the pointer and wraps modulo NREQ.
  always_comb begin
    w_found = 1'b0;
    w_idx   = r_ptr;
    w_cand  = r_ptr;
    w_pos   = 0;
    for (int k = 0; k < NREQ; k++) begin
      w_pos = int'(r_ptr) + k;
      if (w_pos >= NREQ) w_pos = w_pos - NREQ;
      w_cand = PW'(w_pos);
      if (!w_found && req[w_cand]) begin
        w_found = 1'b1;
        w_idx   = w_cand;
      end
    end
    winner = '0;
    if (w_found) winner[w_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (advance && w_found) begin
      r_ptr <= (w_idx == C_LAST) ? '0 : w_idx + PW'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/usb_utmi_tx_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | usb_utmi_tx_arb                                                          |
// | Arbitrates NREQ packet sources onto one UTMI transmit path.              |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module usb_utmi_tx_arb
  import usb_utmi_pkg::*;
#(
  parameter int NREQ       = 2,
  parameter int IPG_CYCLES = USB_TX_ARB_IPG_DEFAULT
) (
  input wire logic          clk,
  input wire logic          rst,
  usb_utmi_tx_arb_if.slave  bus
);
  localparam logic [7:0] C_GAP_LOAD = 8'(IPG_CYCLES - 1);

  usb_tx_arb_state_t r_state;
  logic [NREQ-1:0]   r_grant;
  logic [7:0]        r_gap_cnt;
  logic              r_busy;

  logic [NREQ-1:0]   w_winner;
  logic              w_start;
  logic              w_owner_valid;
  logic              w_tx_valid;
  logic [7:0]        w_data;
  logic [NREQ-1:0]   w_ready;

  assign w_start       = (r_state == IDLE) && (|bus.req_valid) && !bus.utmi_rx_active;
  assign w_owner_valid = |(bus.req_valid & r_grant);

  usb_rr_arb #(
    .NREQ (NREQ)
  ) u_rr_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (bus.req_valid),
    .advance (w_start),
    .winner  (w_winner)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_grant   <= '0;
      r_gap_cnt <= 8'd0;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_state <= XFER;
            r_grant <= w_winner;
            r_busy  <= 1'b1;
          end
        end
        XFER: begin
          if (!w_owner_valid) begin
            r_state   <= GAP;
            r_grant   <= '0;
            r_gap_cnt <= C_GAP_LOAD;
          end
        end
        GAP: begin
          // Loaded with IPG_CYCLES-1 so the exit edge is the IPG_CYCLES-th.
          if (r_gap_cnt == 8'd0) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_gap_cnt <= r_gap_cnt - 8'd1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_grant <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Data path is a pass-through from the granted requester.
  always_comb begin
    w_tx_valid = 1'b0;
    w_data     = 8'h00;
    w_ready    = '0;
    if (r_state == XFER) begin
      for (int i = 0; i < NREQ; i++) begin
        if (r_grant[i]) begin
          w_tx_valid = bus.req_valid[i];
          w_data     = bus.req_data[8*i +: 8];
          w_ready[i] = bus.utmi_tx_ready;
        end
      end
    end
  end

  assign bus.req_ready     = w_ready;
  assign bus.grant         = r_grant;
  assign bus.busy          = r_busy;
  assign bus.utmi_tx_valid = w_tx_valid;
  assign bus.utmi_data_in  = w_data;

endmodule
`default_nettype wire

// File: tb/tb_usb_utmi_tx_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_usb_utmi_tx_arb                                                       |
// | Directed and randomized checks of the arbiter against a reference model. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_usb_utmi_tx_arb;
  import usb_utmi_pkg::*;

  localparam int N    = 2;
  localparam int IPG  = USB_TX_ARB_IPG_DEFAULT;
  localparam int HALF = 5;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic rst_b = 1'b1;
  always #HALF clk = ~clk;

  usb_utmi_tx_arb_if #(.NREQ(N)) bus ();
  usb_utmi_tx_arb_if #(.NREQ(2)) bus_b ();

  usb_utmi_tx_arb #(.NREQ(N), .IPG_CYCLES(IPG)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Second instance exercises the minimum inter-packet gap.
  usb_utmi_tx_arb #(.NREQ(2), .IPG_CYCLES(1)) dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (bus_b)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, got, want, $time);
    end
  endtask

  // Reference model: owner index (-1 none), remaining gap cycles, rr pointer.
  int m_owner = -1;
  int m_gap   = 0;
  int m_ptr   = 0;
  bit m_live  = 1'b0;

  function automatic int rr_pick(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++)
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int o);
    logic [N-1:0] r;
    r = '0;
    if (o >= 0) r[o] = 1'b1;
    return r;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_owner <= -1;
      m_gap   <= 0;
      m_ptr   <= 0;
      m_live  <= 1'b1;
    end else if (m_owner >= 0) begin
      if (!bus.req_valid[m_owner]) begin
        m_owner <= -1;
        m_gap   <= IPG;
      end
    end else if (m_gap > 0) begin
      m_gap <= m_gap - 1;
    end else if (bus.req_valid != '0 && !bus.utmi_rx_active) begin
      m_owner <= rr_pick(bus.req_valid, m_ptr);
      m_ptr   <= (rr_pick(bus.req_valid, m_ptr) + 1) % N;
    end
  end

  logic [N-1:0] acc = '0;

  always @(negedge clk) begin
    #4;
    if (m_live) begin
      chk("grant",    32'(bus.grant), 32'(onehot(m_owner)));
      chk("busy",     32'(bus.busy), 32'((m_owner >= 0) || (m_gap > 0)));
      chk("tx_valid", 32'(bus.utmi_tx_valid),
          32'((m_owner >= 0) ? bus.req_valid[m_owner] : 1'b0));
      chk("data_in",  32'(bus.utmi_data_in),
          32'((m_owner >= 0) ? bus.req_data[8*m_owner +: 8] : 8'h00));
      chk("req_ready", 32'(bus.req_ready),
          32'((m_owner >= 0 && bus.utmi_tx_ready) ? onehot(m_owner) : '0));
      acc <= ((m_owner >= 0 && bus.utmi_tx_ready) ? onehot(m_owner) : '0) & bus.req_valid;
    end else begin
      acc <= '0;
    end
  end

  // Requester behaviour: hold valid for a packet, advance data only on acceptance.
  int rem [N];
  int issued  = 0;
  int done_pk = 0;

  task automatic req_step(input bit allow_new);
    for (int i = 0; i < N; i++) begin
      if (bus.req_valid[i]) begin
        if (acc[i]) begin
          rem[i]--;
          if (rem[i] == 0) begin
            bus.req_valid[i] = 1'b0;
            done_pk++;
          end else begin
            bus.req_data[8*i +: 8] = 8'($urandom);
          end
        end
      end else if (allow_new && $urandom_range(0, 2) == 0) begin
        bus.req_valid[i]       = 1'b1;
        rem[i]                 = int'($urandom_range(1, 5));
        bus.req_data[8*i +: 8] = 8'($urandom);
        issued++;
      end
    end
  endtask

  task automatic wait_grant(input string name, input logic [N-1:0] want);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 30 && !seen; k++) begin
      @(negedge clk);
      #4;
      if (bus.grant != '0) seen = 1'b1;
    end
    chk(name, 32'(bus.grant), 32'(want));
  endtask

  task automatic wait_idle(input string name);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 30 && !seen; k++) begin
      @(negedge clk);
      #4;
      if (!bus.busy) seen = 1'b1;
    end
    chk(name, 32'(bus.busy), 32'(0));
  endtask

  int hs_cnt;
  int gapcnt;
  bit seen_b;
  bit drained;

  initial begin
    bus.req_valid        = '0;
    bus.req_data         = '0;
    bus.utmi_tx_ready    = 1'b1;
    bus.utmi_rx_active   = 1'b0;
    bus_b.req_valid      = '0;
    bus_b.req_data       = '0;
    bus_b.utmi_tx_ready  = 1'b1;
    bus_b.utmi_rx_active = 1'b0;
    for (int i = 0; i < N; i++) rem[i] = 0;

    repeat (3) @(negedge clk);
    #4;
    chk("reset_grant", 32'(bus.grant), 32'(0));
    chk("reset_busy",  32'(bus.busy), 32'(0));
    chk("reset_txv",   32'(bus.utmi_tx_valid), 32'(0));
    chk("reset_data",  32'(bus.utmi_data_in), 32'(0));

    // Single 3-byte packet from requester 0.
    @(negedge clk); rst = 1'b0; bus.req_valid[0] = 1'b1; bus.req_data[7:0] = 8'hC3;
    #4 chk("spkt_latency", 32'(bus.grant), 32'(0));
    @(negedge clk);
    #4 chk("spkt_grant", 32'(bus.grant), 32'h1);
    chk("spkt_b0", 32'(bus.utmi_data_in), 32'hC3);
    @(negedge clk); bus.req_data[7:0] = 8'h11;
    #4 chk("spkt_b1", 32'(bus.utmi_data_in), 32'h11);
    @(negedge clk); bus.req_data[7:0] = 8'h22;
    #4 chk("spkt_b2", 32'(bus.utmi_data_in), 32'h22);
    @(negedge clk); bus.req_valid[0] = 1'b0;
    #4 chk("spkt_end_txv", 32'(bus.utmi_tx_valid), 32'(0));
    repeat (4) @(negedge clk);
    #4 chk("spkt_gap_busy", 32'(bus.busy), 32'(1));
    @(negedge clk);
    #4 chk("spkt_idle_busy", 32'(bus.busy), 32'(0));

    // Contention from pointer 0, with requester 0 re-raising during the gap.
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    bus.req_valid = 2'b11; bus.req_data = {8'hB0, 8'hA0};
    #4 chk("cont_wait", 32'(bus.grant), 32'(0));
    @(negedge clk);
    #4 chk("cont_first", 32'(bus.grant), 32'h1);
    chk("cont_loser_ready", 32'(bus.req_ready), 32'h1);
    @(negedge clk); bus.req_data[7:0] = 8'hA1;
    @(negedge clk); bus.req_valid[0] = 1'b0;
    @(negedge clk); bus.req_valid[0] = 1'b1; bus.req_data[7:0] = 8'hA2;
    wait_grant("cont_second", 2'b10);
    chk("cont_second_data", 32'(bus.utmi_data_in), 32'hB0);
    @(negedge clk); bus.req_valid[1] = 1'b0;
    wait_grant("cont_third", 2'b01);
    chk("cont_third_data", 32'(bus.utmi_data_in), 32'hA2);
    @(negedge clk); bus.req_valid[0] = 1'b0;
    wait_idle("cont_idle");

    // RX activity blocks new grants but not a running transfer.
    @(negedge clk); bus.utmi_rx_active = 1'b1; bus.req_valid[1] = 1'b1; bus.req_data[15:8] = 8'hC5;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      #4 chk("rx_block", 32'(bus.grant), 32'(0));
    end
    @(negedge clk); bus.utmi_rx_active = 1'b0;
    #4 chk("rx_still_blocked", 32'(bus.grant), 32'(0));
    @(negedge clk);
    #4 chk("rx_grant", 32'(bus.grant), 32'h2);
    @(negedge clk); bus.utmi_rx_active = 1'b1; bus.req_data[15:8] = 8'hC6;
    @(negedge clk); bus.req_data[15:8] = 8'hC7;
    #4 chk("rx_mid_txv", 32'(bus.utmi_tx_valid), 32'(1));
    chk("rx_mid_data", 32'(bus.utmi_data_in), 32'hC7);
    @(negedge clk); bus.req_valid[1] = 1'b0; bus.utmi_rx_active = 1'b0;
    wait_idle("rx_idle");

    // Backpressure: ready pattern 1,0,0 repeating on a 4-byte packet.
    @(negedge clk);
    bus.req_valid[0] = 1'b1; rem[0] = 4; bus.req_data[7:0] = 8'hD0;
    hs_cnt = 0;
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      bus.utmi_tx_ready = (k % 3 == 0);
      req_step(1'b0);
      #4;
      if (bus.utmi_tx_valid && bus.utmi_tx_ready) hs_cnt++;
    end
    chk("bp_bytes", 32'(hs_cnt), 32'(4));
    bus.utmi_tx_ready = 1'b1;
    wait_idle("bp_idle");

    // Reset during a 5-byte packet after two bytes; pointer must return to 0.
    @(negedge clk); bus.req_valid[0] = 1'b1; bus.req_data[7:0] = 8'hE0;
    @(negedge clk);
    #4 chk("rstx_grant", 32'(bus.grant), 32'h1);
    @(negedge clk); bus.req_data[7:0] = 8'hE1;
    @(negedge clk); bus.req_data[7:0] = 8'hE2; rst = 1'b1; bus.req_valid[0] = 1'b0;
    @(negedge clk); rst = 1'b0; bus.req_valid = 2'b11;
    #4 chk("rstx_grant0", 32'(bus.grant), 32'(0));
    chk("rstx_txv0", 32'(bus.utmi_tx_valid), 32'(0));
    chk("rstx_busy0", 32'(bus.busy), 32'(0));
    @(negedge clk);
    #4 chk("rstx_ptr0", 32'(bus.grant), 32'h1);
    @(negedge clk); bus.req_valid = 2'b00;
    wait_idle("rstx_idle");

    // Randomized traffic with backpressure, RX activity and occasional resets.
    issued = 0; done_pk = 0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 99) == 0);
      bus.utmi_tx_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) == 0) bus.utmi_rx_active = ~bus.utmi_rx_active;
      req_step(1'b1);
    end
    @(negedge clk);
    rst = 1'b0; bus.utmi_rx_active = 1'b0; bus.utmi_tx_ready = 1'b1;
    drained = 1'b0;
    for (int c = 0; c < 300 && !drained; c++) begin
      @(negedge clk);
      req_step(1'b0);
      #4;
      if (bus.req_valid == '0 && !bus.busy) drained = 1'b1;
    end
    chk("drain_idle", 32'(drained), 32'(1));
    chk("drain_packets", 32'(done_pk), 32'(issued));

    // Minimum gap: requester 0 re-raises one cycle after its packet ends.
    @(negedge clk); rst_b = 1'b0; bus_b.req_valid[0] = 1'b1; bus_b.req_data[7:0] = 8'h51;
    @(negedge clk);
    #4 chk("ipg1_grant", 32'(bus_b.grant), 32'h1);
    chk("ipg1_b0", 32'(bus_b.utmi_data_in), 32'h51);
    @(negedge clk); bus_b.req_data[7:0] = 8'h52;
    @(negedge clk); bus_b.req_valid[0] = 1'b0;
    gapcnt = 0; seen_b = 1'b0;
    for (int k = 0; k < 10 && !seen_b; k++) begin
      @(negedge clk);
      if (k == 0) begin
        bus_b.req_valid[0] = 1'b1;
        bus_b.req_data[7:0] = 8'h53;
      end
      #4;
      if (bus_b.grant != '0) seen_b = 1'b1;
      else if (bus_b.busy) gapcnt++;
    end
    chk("ipg1_gap_cycles", 32'(gapcnt), 32'(1));
    chk("ipg1_regrant", 32'(bus_b.grant), 32'h1);
    chk("ipg1_data", 32'(bus_b.utmi_data_in), 32'h53);
    @(negedge clk); bus_b.req_valid[0] = 1'b0;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
`default_nettype wire
